otter_mem_arbiter: RTL and testbench
====================================

Name: otter_mem_arbiter

Overview:
Arbitrates the OTTER memory data port (port 2: byte-addressed, synchronous-read, MMIO above 0x0001_0000) between NREQ requesters, e.g. CPU load/store unit (req 0) and DMA/debug engine (req 1).
Sequences each access so that address, size and sign stay stable through the memory's registered-read / combinational-sizing return cycle.
Returns registered read data to the winning requester.
The instruction port (port 1) is not touched.

Parameters:
NREQ, 2, number of requesters (2..4)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
MEM_CLK  in  1  clock, shared with the memory
MEM_RST_N  in  1  asynchronous active-low reset
REQ  in  NREQ  per-requester access request; held until ACK
REQ_WE  in  NREQ  1 = write, 0 = read
REQ_ADDR  in  NREQ*32  byte address, slice i
REQ_DIN  in  NREQ*32  write data, slice i
REQ_SIZE  in  NREQ*2  0 = byte, 1 = half, 2 = word
REQ_SIGN  in  NREQ  1 = unsigned, 0 = signed
ACK  out  NREQ  one-cycle pulse: command issued to memory
RVALID  out  NREQ  one-cycle pulse: RDATA valid for requester i
RDATA  out  32  read data, shared; qualify with RVALID
BUSY  out  1  state != IDLE
M_RDEN2  out  1  to memory MEM_RDEN2
M_WE2  out  1  to memory MEM_WE2
M_ADDR2  out  32  to memory MEM_ADDR2
M_DIN2  out  32  to memory MEM_DIN2
M_SIZE  out  2  to memory MEM_SIZE
M_SIGN  out  1  to memory MEM_SIGN
M_DOUT2  in  32  from memory MEM_DOUT2 (sized, sign-extended, or IO buffer)

Behaviour:
- Reset (async, MEM_RST_N = 0):
  - state = IDLE; rr pointer = 0.
  - Command register cleared.
  - All outputs 0: ACK, RVALID, RDATA, BUSY, all M_*.
  - Reset mid-transaction abandons the access with no ACK/RVALID. A write already clocked into memory stays written.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any REQ is high, select the winner and latch its WE/ADDR/DIN/SIZE/SIGN and index into the command register.
  - Next state is ACCESS. With no REQ, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - M_ADDR2/M_DIN2/M_SIZE/M_SIGN come from the command register.
  - M_WE2 = cmd_we; M_RDEN2 = !cmd_we; ACK[winner] = 1.
  - Write: next state is IDLE.
  - Read: next state is RESP.
- RESP (1 cycle):
  - M_ADDR2/M_SIZE/M_SIGN held from the command register; M_RDEN2 = M_WE2 = 0.
  - M_DOUT2 sampled into RDATA at the end of RESP.
  - Next cycle: state IDLE, RVALID[winner] = 1 for one cycle.
  - Arbitration may occur in that same IDLE cycle.
- M_* outputs in IDLE:
  - M_RDEN2 = M_WE2 = 0.
  - Address/data/size/sign hold their last values (no toggling), so a late sizing mux still sees stable inputs.
- Latency:
  - Read: REQ sampled at edge 0 → ACK in cycle 1 → RVALID in cycle 3.
  - Write: ACK in cycle 1.
  - Throughput: one write per 2 cycles, one read per 3 cycles.
- Arbitration:
  - PRIO_MODE = 0: search starts at rr pointer; after a grant, pointer = winner + 1, mod NREQ.
  - PRIO_MODE = 1: lowest index wins; pointer unused.
  - Requests arriving while BUSY wait; there is no queueing beyond the REQ level.
- Requester rules:
  - A requester must hold REQ and its command until ACK.
  - It drops REQ the cycle after ACK, or keeps it high for a new command.
  - A REQ dropped before ACK is simply not granted. The command is latched only in IDLE, so later changes are ignored.
- MMIO: addresses ≥ 0x0001_0000 pass through unchanged. IO_WR and IO buffer capture are the memory's job; the timing is identical.
- Size/offset: no checking. Unsupported size/offset combinations are forwarded; the memory ignores such writes and returns 0 for such reads, and RVALID still pulses.
- Exactly one of ACK/RVALID is set per winner event. ACK and RVALID are never high for two requesters in the same cycle.

Decomposition:
- Package otter_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - size constants SZ_BYTE = 0, SZ_HALF = 1, SZ_WORD = 2
  - MMIO_BASE = 32'h0001_0000
  - cmd_t struct {we, addr, din, size, sign, idx}
- Sub-module otter_rr_picker: combinational round-robin/fixed picker (req vector, pointer, mode → one-hot grant, index, any).

Test Plan:
- Single read, req0, addr 0x0000_0104, size 2; memory word 0xDEADBEEF → ACK[0] in cycle 1, M_RDEN2 = 1 for one cycle only, M_ADDR2 stable in cycles 1-2, RVALID[0] in cycle 3 with RDATA = 0xDEADBEEF.
- Signed byte read, addr 0x0000_0107, word 0x80FF_0000 → RDATA = 0xFFFF_FF80. Same access with SIGN = 1 → RDATA = 0x0000_0080.
- REQ[0] and REQ[1] held continuously with writes, PRIO_MODE = 0 → ACK alternates 0, 1, 0, 1 every 2 cycles. With PRIO_MODE = 1, only ACK[0] fires until REQ[0] drops.
- Write sh 0xABCD to 0x0000_0202 by req1, then read word 0x200 by req0 → RDATA[31:16] = 0xABCD. M_WE2 pulses exactly once.
- MMIO read at 0x1100_0000 with IO_IN = 0x1234_5678 → RVALID with RDATA = 0x1234_5678. MMIO write → M_WE2 pulse with address held.
- Assert MEM_RST_N low during RESP → all outputs 0 immediately and no RVALID. After release, a new REQ[1] is served normally.

Source files
------------

// File: rtl/otter_mem_arbiter_pkg.sv
// Shared types and constants for the OTTER data-port arbiter.
package otter_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0]  SZ_BYTE   = 2'd0;
    localparam logic [1:0]  SZ_HALF   = 2'd1;
    localparam logic [1:0]  SZ_WORD   = 2'd2;
    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

    // Wide enough for up to four requesters.
    localparam int IDX_W = 2;

    typedef struct packed {
        logic             we;
        logic [31:0]      addr;
        logic [31:0]      din;
        logic [1:0]       size;
        logic             sign;
        logic [IDX_W-1:0] idx;
    } cmd_t;

endpackage

// File: rtl/otter_mem_arbiter_if.sv
// Requester-side and memory-side signals of the OTTER data-port arbiter.
interface otter_mem_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    REQ;
    logic [NREQ-1:0]    REQ_WE;
    logic [NREQ*32-1:0] REQ_ADDR;
    logic [NREQ*32-1:0] REQ_DIN;
    logic [NREQ*2-1:0]  REQ_SIZE;
    logic [NREQ-1:0]    REQ_SIGN;
    logic [NREQ-1:0]    ACK;
    logic [NREQ-1:0]    RVALID;
    logic [31:0]        RDATA;
    logic               BUSY;
    logic               M_RDEN2;
    logic               M_WE2;
    logic [31:0]        M_ADDR2;
    logic [31:0]        M_DIN2;
    logic [1:0]         M_SIZE;
    logic               M_SIGN;
    logic [31:0]        M_DOUT2;

    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_DIN, REQ_SIZE, REQ_SIGN, M_DOUT2,
        input  ACK, RVALID, RDATA, BUSY, M_RDEN2, M_WE2, M_ADDR2, M_DIN2, M_SIZE, M_SIGN
    );

    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_DIN, REQ_SIZE, REQ_SIGN, M_DOUT2,
        output ACK, RVALID, RDATA, BUSY, M_RDEN2, M_WE2, M_ADDR2, M_DIN2, M_SIZE, M_SIGN
    );

endinterface

// File: rtl/otter_mem_arbiter_rr_picker.sv
// Combinational requester picker: round-robin from ptr, or fixed lowest-index when mode is set.
module otter_rr_picker
    import otter_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             mode,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] start;

    assign start = mode ? '0 : ptr;

    // First pass covers [start, NREQ), second pass wraps around to [0, start).
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (IDX_W'(i) >= start)) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbitrates the OTTER memory data port between NREQ requesters and returns
// registered read data; the command stays on M_* through the sized-read return cycle.
module otter_mem_arbiter
    import otter_arb_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic               MEM_CLK,
    input  logic               MEM_RST_N,
    otter_mem_arbiter_if.slave bus
);

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_sel;
    logic [IDX_W-1:0] ptr_q, win_idx, ptr_next;
    logic [NREQ-1:0]  grant, ack, rvalid_q;
    logic             any_req;
    logic [31:0]      rdata_q;

    otter_rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (bus.REQ),
        .ptr   (ptr_q),
        .mode  (PRIO_MODE != 0),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_req)
    );

    always_comb begin
        cmd_sel     = '0;
        cmd_sel.idx = win_idx;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                cmd_sel.we   = bus.REQ_WE[i];
                cmd_sel.addr = bus.REQ_ADDR[i*32 +: 32];
                cmd_sel.din  = bus.REQ_DIN[i*32 +: 32];
                cmd_sel.size = bus.REQ_SIZE[i*2 +: 2];
                cmd_sel.sign = bus.REQ_SIGN[i];
            end
        end
    end

    assign ptr_next = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = cmd_q.we ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            ptr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NREQ; i++) begin
                rvalid_q[i] <= (state_q == RESP) && (cmd_q.idx == IDX_W'(i));
            end
            if (state_q == RESP) rdata_q <= bus.M_DOUT2;
            // The command register only loads in IDLE, so the memory sees stable inputs otherwise.
            if (state_q == IDLE && any_req) begin
                cmd_q <= cmd_sel;
                ptr_q <= ptr_next;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = (state_q == ACCESS) && (cmd_q.idx == IDX_W'(i));
        end
    end

    assign bus.ACK     = ack;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.BUSY    = (state_q != IDLE);
    assign bus.M_RDEN2 = (state_q == ACCESS) && !cmd_q.we;
    assign bus.M_WE2   = (state_q == ACCESS) && cmd_q.we;
    assign bus.M_ADDR2 = cmd_q.addr;
    assign bus.M_DIN2  = cmd_q.din;
    assign bus.M_SIZE  = cmd_q.size;
    assign bus.M_SIGN  = cmd_q.sign;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: behavioural OTTER port-2 memory, vector table, scoreboard.
module tb_otter_mem_arbiter;
    import otter_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int NVEC = 16;

    logic MEM_CLK   = 1'b0;
    logic MEM_RST_N = 1'b0;
    always #5 MEM_CLK = ~MEM_CLK;

    otter_mem_arbiter_if #(.NREQ(NREQ)) bus0 ();
    otter_mem_arbiter_if #(.NREQ(NREQ)) bus1 ();

    otter_mem_arbiter #(.NREQ(NREQ), .PRIO_MODE(0)) dut_rr (
        .MEM_CLK   (MEM_CLK),
        .MEM_RST_N (MEM_RST_N),
        .bus       (bus0)
    );

    otter_mem_arbiter #(.NREQ(NREQ), .PRIO_MODE(1)) dut_fp (
        .MEM_CLK   (MEM_CLK),
        .MEM_RST_N (MEM_RST_N),
        .bus       (bus1)
    );

    // The fixed-priority instance sees the same requests.
    assign bus1.REQ      = bus0.REQ;
    assign bus1.REQ_WE   = bus0.REQ_WE;
    assign bus1.REQ_ADDR = bus0.REQ_ADDR;
    assign bus1.REQ_DIN  = bus0.REQ_DIN;
    assign bus1.REQ_SIZE = bus0.REQ_SIZE;
    assign bus1.REQ_SIGN = bus0.REQ_SIGN;
    assign bus1.M_DOUT2  = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural memory: registered read, combinational sizing, IO buffer above MMIO_BASE.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_word     = 32'h0;
    logic        rd_io       = 1'b0;
    logic [31:0] io_in       = 32'h1234_5678;
    logic [31:0] io_wr_addr  = 32'h0;
    logic [31:0] io_wr_data  = 32'h0;
    int          we_pulses   = 0;
    int          rden_pulses = 0;

    function automatic logic [31:0] read_size(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
        logic [31:0] s;
        s = w >> (8 * off);
        case (sz)
            SZ_BYTE: return uns ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
            SZ_HALF: begin
                if (off == 2'd3) return 32'h0;
                return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            end
            SZ_WORD: return (off == 2'd0) ? w : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] write_merge(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        int          sh;
        r  = w;
        sh = 8 * int'(off);
        case (sz)
            SZ_BYTE: r[sh +: 8] = d[7:0];
            SZ_HALF: if (off != 2'd3) r[sh +: 16] = d[15:0];
            SZ_WORD: if (off == 2'd0) r = d;
            default: r = w;
        endcase
        return r;
    endfunction

    always @(posedge MEM_CLK) begin
        if (bus0.M_RDEN2) begin
            rden_pulses <= rden_pulses + 1;
            rd_io       <= (bus0.M_ADDR2 >= MMIO_BASE);
            rd_word     <= (bus0.M_ADDR2 >= MMIO_BASE) ? io_in : mem[bus0.M_ADDR2[11:2]];
        end
        if (bus0.M_WE2) begin
            we_pulses <= we_pulses + 1;
            if (bus0.M_ADDR2 >= MMIO_BASE) begin
                io_wr_addr <= bus0.M_ADDR2;
                io_wr_data <= bus0.M_DIN2;
            end else begin
                mem[bus0.M_ADDR2[11:2]] <= write_merge(mem[bus0.M_ADDR2[11:2]], bus0.M_ADDR2[1:0],
                                                       bus0.M_SIZE, bus0.M_DIN2);
            end
        end
    end

    assign bus0.M_DOUT2 = rd_io ? rd_word
                                : read_size(rd_word, bus0.M_ADDR2[1:0], bus0.M_SIZE, bus0.M_SIGN);

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always @(negedge MEM_CLK) begin
        exp_t e;
        if (MEM_RST_N) begin
            if (bus0.ACK != '0) check("ack_onehot", 128'($countones(bus0.ACK)), 128'd1);
            if (bus0.RVALID != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rvalid", {126'h0, bus0.RVALID}, 128'h0);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_idx", {126'h0, bus0.RVALID}, 128'(1 << e.idx));
                    check("rdata", {96'h0, bus0.RDATA}, {96'h0, e.data});
                end
            end
        end
    end

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge MEM_CLK);
        #1;
    endtask

    task automatic clear_req();
        bus0.REQ      = '0;
        bus0.REQ_WE   = '0;
        bus0.REQ_ADDR = '0;
        bus0.REQ_DIN  = '0;
        bus0.REQ_SIZE = '0;
        bus0.REQ_SIGN = '0;
    endtask

    task automatic drive(input vec_t v);
        clear_req();
        bus0.REQ[v.idx]               = 1'b1;
        bus0.REQ_WE[v.idx]            = v.we;
        bus0.REQ_ADDR[v.idx*32 +: 32] = v.addr;
        bus0.REQ_DIN[v.idx*32 +: 32]  = v.din;
        bus0.REQ_SIZE[v.idx*2 +: 2]   = v.size;
        bus0.REQ_SIGN[v.idx]          = v.sign;
    endtask

    task automatic wait_ack(input int idx);
        int c;
        for (c = 0; c < 8; c++) begin
            tick();
            if (bus0.ACK[idx]) break;
        end
        check("ack_latency", 128'(c), 128'd0);
        check("ack_vec", {126'h0, bus0.ACK}, 128'(1 << idx));
    endtask

    task automatic drain();
        for (int c = 0; c < 6 && sb.size() != 0; c++) tick();
        check("drain", 128'(sb.size()), 128'd0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        drive(v);
        if (!v.we) sb.push_back('{v.idx, v.exp});
        wait_ack(v.idx);
        check("cmd", {bus0.M_RDEN2, bus0.M_WE2, bus0.M_ADDR2, bus0.M_DIN2, bus0.M_SIZE, bus0.M_SIGN, bus0.BUSY},
                     {!v.we, v.we, v.addr, v.din, v.size, v.sign, 1'b1});
        clear_req();
        tick();
        check("hold", {bus0.M_RDEN2, bus0.M_WE2, bus0.M_ADDR2, bus0.M_SIZE, bus0.M_SIGN},
                      {2'b00, v.addr, v.size, v.sign});
        if (!v.we) drain();
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus0.ACK, bus0.RVALID, bus0.RDATA, bus0.BUSY, bus0.M_RDEN2, bus0.M_WE2,
                     bus0.M_ADDR2, bus0.M_DIN2, bus0.M_SIZE, bus0.M_SIGN}, 128'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h104 >> 2] = 32'hDEAD_BEEF;
        mem[32'h108 >> 2] = 32'hCAFE_BABE;

        vecs[0]  = '{1, 1'b1, 32'h0000_0104, 32'h80FF_0000, SZ_WORD, 1'b0, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h0000_0107, 32'h0,         SZ_BYTE, 1'b0, 32'hFFFF_FF80};
        vecs[2]  = '{0, 1'b0, 32'h0000_0107, 32'h0,         SZ_BYTE, 1'b1, 32'h0000_0080};
        vecs[3]  = '{1, 1'b1, 32'h0000_0202, 32'h0000_ABCD, SZ_HALF, 1'b0, 32'h0};
        vecs[4]  = '{0, 1'b0, 32'h0000_0200, 32'h0,         SZ_WORD, 1'b0, 32'hABCD_0000};
        vecs[5]  = '{1, 1'b0, 32'h0000_010A, 32'h0,         SZ_HALF, 1'b0, 32'hFFFF_CAFE};
        vecs[6]  = '{1, 1'b0, 32'h0000_0109, 32'h0,         SZ_BYTE, 1'b1, 32'h0000_00BA};
        vecs[7]  = '{0, 1'b0, 32'h1100_0000, 32'h0,         SZ_WORD, 1'b0, 32'h1234_5678};
        vecs[8]  = '{0, 1'b1, 32'h1100_0004, 32'hCAFE_F00D, SZ_WORD, 1'b0, 32'h0};
        vecs[9]  = '{1, 1'b0, 32'h0000_010B, 32'h0,         SZ_HALF, 1'b0, 32'h0};
        vecs[10] = '{1, 1'b1, 32'h0000_0300, 32'h1122_3344, SZ_WORD, 1'b0, 32'h0};
        vecs[11] = '{0, 1'b0, 32'h0000_0301, 32'h0,         SZ_BYTE, 1'b1, 32'h0000_0033};
        vecs[12] = '{0, 1'b1, 32'h0000_0302, 32'h0000_00AA, SZ_BYTE, 1'b0, 32'h0};
        vecs[13] = '{1, 1'b0, 32'h0000_0300, 32'h0,         SZ_WORD, 1'b0, 32'h11AA_3344};
        vecs[14] = '{0, 1'b0, 32'h0000_0106, 32'h0,         SZ_HALF, 1'b1, 32'h0000_80FF};
        vecs[15] = '{1, 1'b0, 32'h0000_0105, 32'h0,         SZ_WORD, 1'b0, 32'h0};

        // Reset state
        clear_req();
        #12;
        check_all_zero("reset_outputs");
        tick();
        MEM_RST_N = 1'b1;
        tick();
        check("idle_after_reset", {127'h0, bus0.BUSY}, 128'h0);

        // Single word read with cycle-by-cycle timing
        v = '{0, 1'b0, 32'h0000_0104, 32'h0, SZ_WORD, 1'b0, 32'hDEAD_BEEF};
        drive(v);
        sb.push_back('{0, 32'hDEAD_BEEF});
        tick();
        check("c1_ack", {126'h0, bus0.ACK}, 128'h1);
        check("c1_rden", {126'h0, bus0.M_RDEN2, bus0.M_WE2}, 128'h2);
        check("c1_addr", {96'h0, bus0.M_ADDR2}, 128'h104);
        clear_req();
        tick();
        check("c2_ack", {126'h0, bus0.ACK}, 128'h0);
        check("c2_rden", {126'h0, bus0.M_RDEN2, bus0.M_WE2}, 128'h0);
        check("c2_addr", {96'h0, bus0.M_ADDR2}, 128'h104);
        check("c2_busy", {127'h0, bus0.BUSY}, 128'h1);
        tick();
        check("c3_rvalid", {126'h0, bus0.RVALID}, 128'h1);
        check("c3_rdata", {96'h0, bus0.RDATA}, 128'hDEAD_BEEF);
        check("c3_busy", {127'h0, bus0.BUSY}, 128'h0);
        drain();

        // Vector table
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);
        check("io_wr_addr", {96'h0, io_wr_addr}, 128'h1100_0004);
        check("io_wr_data", {96'h0, io_wr_data}, 128'hCAFE_F00D);
        check("we_pulses", 128'(we_pulses), 128'd5);
        check("rden_pulses", 128'(rden_pulses), 128'd12);

        // Reset asserted during RESP abandons the read
        v = '{1, 1'b0, 32'h0000_0104, 32'h0, SZ_WORD, 1'b0, 32'h0};
        drive(v);
        wait_ack(1);
        clear_req();
        tick();
        check("resp_busy", {127'h0, bus0.BUSY}, 128'h1);
        #2;
        MEM_RST_N = 1'b0;
        #1;
        check_all_zero("reset_in_resp");
        tick();
        tick();
        MEM_RST_N = 1'b1;
        tick();
        check_all_zero("after_release");
        run_vec('{1, 1'b0, 32'h0000_0104, 32'h0, SZ_WORD, 1'b0, 32'h80FF_0000});

        // Both requesters streaming writes: alternation vs fixed priority
        bus0.REQ      = 2'b11;
        bus0.REQ_WE   = 2'b11;
        bus0.REQ_ADDR = {32'h0000_0404, 32'h0000_0400};
        bus0.REQ_DIN  = {32'h0000_0002, 32'h0000_0001};
        bus0.REQ_SIZE = {SZ_WORD, SZ_WORD};
        bus0.REQ_SIGN = 2'b00;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("rr_ack", {126'h0, bus0.ACK},
                  (c % 2 != 0) ? 128'h0 : ((c % 4 == 0) ? 128'h1 : 128'h2));
            check("fp_ack", {126'h0, bus1.ACK}, (c % 2 != 0) ? 128'h0 : 128'h1);
        end
        bus0.REQ[0] = 1'b0;
        tick();
        check("fp_ack_after_drop", {126'h0, bus1.ACK}, 128'h2);
        check("rr_ack_after_drop", {126'h0, bus0.ACK}, 128'h2);
        clear_req();
        tick();
        tick();
        check("rr_mem_400", {96'h0, mem[32'h400 >> 2]}, 128'h1);
        check("rr_mem_404", {96'h0, mem[32'h404 >> 2]}, 128'h2);
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
